cache_mem_arbiter: RTL and testbench

Memory-side responder for the cache/control interface: it accepts instruction-read, data-read and data-write requests from the cache block and serialises them onto a single-port RAM with a ready/busy handshake. It drives the `iwait`/`dwait` lines that the caches use to derive `ihit`/`dhit`, and returns RAM read data on `iload`/`dload`. Data requests have priority over instruction fetches, and a bounded fairness counter prevents fetch starvation.

---
 rtl/cache_mem_arbiter_if.sv | 54 +++++
 rtl/cache_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
//
// Bundles the cache-side request/response lines and the RAM-side strobe/status
// lines seen by cache_mem_arbiter.
//
//   Cache side : iREN, dREN, dWEN, iaddr, daddr, dstore   (requests)
//                iwait, dwait, iload, dload               (responses)
//   RAM side   : ramREN, ramWEN, ramaddr, ramstore        (commands)
//                ramload, ramstate                        (RAM answer)
//   Status     : err (sticky timeout / RAM error flag)
//
// Modports
//   slave  : the arbiter (answers the caches, commands the RAM)
//   master : the environment (caches issuing requests, RAM answering them)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if;

  // Cache requests
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic [31:0] dstore;

  // Cache responses
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;

  // RAM port
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  // Status
  logic        err;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Memory-side responder for the instruction and data caches. Serialises
// instruction reads, data reads and data writes onto one single-port RAM.
// Data requests win over instruction fetches, except that after STARVE_LIMIT
// consecutive data completions with a fetch pending, the fetch is forced
// through. A grant that sees neither ACCESS nor ERROR for RAM_TIMEOUT cycles
// is abandoned and the sticky err flag is raised.
//
// Parameters
//   STARVE_LIMIT : data grants allowed while iREN waits (1..15)
//   RAM_TIMEOUT  : grant cycles without ACCESS before abort (1..65535)
//
// Ports
//   CLK  : clock, rising edge
//   RST  : asynchronous, active-high reset
//   bus  : cache_mem_arbiter_if.slave
//          in : iREN dREN dWEN iaddr daddr dstore ramload ramstate
//          out: iwait dwait iload dload ramREN ramWEN ramaddr ramstore err
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned RAM_TIMEOUT  = 255
) (
  input  logic               CLK,
  input  logic               RST,
  cache_mem_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(RAM_TIMEOUT + 1);

  localparam logic [1:0]    RAM_ACCESS = 2'b10;
  localparam logic [1:0]    RAM_ERROR  = 2'b11;
  localparam logic [3:0]    SCNT_LIMIT = 4'(STARVE_LIMIT);
  // The counter holds the number of grant cycles already spent without
  // ACCESS, so the cycle that would make it RAM_TIMEOUT is the last one.
  localparam logic [TW-1:0] TCNT_LAST  = TW'(RAM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [31:0]   r_addr;    // address owned by the current grant
  logic [31:0]   r_store;   // write data owned by the current grant
  logic          r_wr;      // current data grant is a write
  logic          r_ramren;
  logic          r_ramwen;
  logic          r_err;
  logic [TW-1:0] r_tcnt;    // grant cycles spent without ACCESS
  logic [3:0]    r_scnt;    // data completions while a fetch was pending

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  state_t w_state_nxt;
  logic   w_dreq;
  logic   w_access;
  logic   w_starve;
  logic   w_grant;
  logic   w_cancel;   // owning request withdrawn or its address changed
  logic   w_fault;    // RAM error or timeout expiry
  logic   w_done;     // completion pulse this cycle

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_access = (bus.ramstate == RAM_ACCESS);
  assign w_starve = bus.iREN && (r_scnt == SCNT_LIMIT);
  assign w_grant  = (r_state == DGNT) || (r_state == IGNT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cancel    = 1'b0;
    w_fault     = 1'b0;
    w_done      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_dreq && !w_starve) begin
          w_state_nxt = DGNT;
        end else if (bus.iREN) begin
          w_state_nxt = IGNT;
        end
      end

      DGNT, IGNT: begin
        if (r_state == DGNT) begin
          // A read that turns into a write (or vice versa) is a new request.
          w_cancel = !(r_wr ? bus.dWEN : bus.dREN) || (bus.daddr != r_addr);
        end else begin
          w_cancel = !bus.iREN || (bus.iaddr != r_addr);
        end

        // ACCESS excludes both ERROR and a timeout in the same cycle, so only
        // a cancel can suppress a completion.
        w_fault = (bus.ramstate == RAM_ERROR) ||
                  (!w_access && (r_tcnt == TCNT_LAST));
        w_done  = w_access && !w_cancel;

        if (w_cancel || w_access || w_fault) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_ramren <= 1'b0;
      r_ramwen <= 1'b0;
      r_err    <= 1'b0;
      r_tcnt   <= '0;
      r_scnt   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == IDLE) begin
        if (w_state_nxt == DGNT) begin
          r_addr   <= bus.daddr;
          r_store  <= bus.dstore;
          r_wr     <= bus.dWEN;
          r_ramren <= !bus.dWEN;
          r_ramwen <= bus.dWEN;
          r_tcnt   <= '0;
        end else if (w_state_nxt == IGNT) begin
          r_addr   <= bus.iaddr;
          r_wr     <= 1'b0;
          r_ramren <= 1'b1;
          r_ramwen <= 1'b0;
          r_tcnt   <= '0;
        end
      end

      if (w_grant) begin
        if (w_state_nxt == IDLE) begin
          r_ramren <= 1'b0;
          r_ramwen <= 1'b0;
        end

        // Never exceeds RAM_TIMEOUT: the grant is left when it would.
        if (!w_access) begin
          r_tcnt <= r_tcnt + TW'(1);
        end

        if (w_fault) begin
          r_err <= 1'b1;
        end

        if (w_done) begin
          if (r_state == IGNT || !bus.iREN) begin
            r_scnt <= '0;
          end else if (r_scnt != SCNT_LIMIT) begin
            r_scnt <= r_scnt + 4'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.iwait    = !((r_state == IGNT) && w_done);
  assign bus.dwait    = !((r_state == DGNT) && w_done);
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = r_ramren;
  assign bus.ramWEN   = r_ramwen;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
  assign bus.err      = r_err;

  // ---------------------------------------------------------------------------
  // Interface contract
  // ---------------------------------------------------------------------------
  // The data cache never asks for a read and a write at once.
  a_no_rd_wr: assert property (@(posedge CLK) disable iff (RST)
    !(bus.dREN && bus.dWEN));

  // Only one requester can own the RAM, so at most one wait line drops.
  a_one_hit: assert property (@(posedge CLK) disable iff (RST)
    bus.iwait || bus.dwait);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Directed stimulus for cache_mem_arbiter (STARVE_LIMIT=4, RAM_TIMEOUT=8).
// Requester tasks push the expected completion into a scoreboard queue; a
// monitor pops one entry for every wait pulse and compares port, address,
// strobes and data. A small RAM model answers ACCESS one cycle after a strobe,
// or stays BUSY, or reports ERROR, depending on ram_mode.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int BUDGET = 100;

  localparam logic [1:0] RS_FREE   = 2'b00;
  localparam logic [1:0] RS_BUSY   = 2'b01;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  logic CLK = 1'b0;
  logic RST;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(
    .STARVE_LIMIT(4),
    .RAM_TIMEOUT (8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // RAM model: 0 = ACCESS one cycle after the strobe, 1 = stuck BUSY, 2 = ERROR
  // ---------------------------------------------------------------------------
  int ram_mode = 0;
  int ram_cnt  = 0;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h8C22_0004 : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge CLK) ram_cnt <= (bus.ramREN || bus.ramWEN) ? ram_cnt + 1 : 0;

  always_comb begin
    bus.ramstate = RS_FREE;
    bus.ramload  = 32'h0;
    if (bus.ramREN || bus.ramWEN) begin
      if (ram_mode == 2) begin
        bus.ramstate = RS_ERROR;
      end else if (ram_mode == 0 && ram_cnt >= 1) begin
        bus.ramstate = RS_ACCESS;
        bus.ramload  = ram_word(bus.ramaddr);
      end else begin
        bus.ramstate = RS_BUSY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          is_i;
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic expect_txn(input bit is_i, input bit is_wr,
                            input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_i  = is_i;
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    sb.push_back(e);
  endtask

  exp_t mon_e;

  always @(negedge CLK) begin
    if (RST === 1'b0 && (bus.iwait !== 1'b1 || bus.dwait !== 1'b1)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.iwait, bus.dwait}, 32'd3);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.is_i ? "iwait_pulse" : "dwait_pulse",
              {30'd0, bus.iwait, bus.dwait}, mon_e.is_i ? 32'd1 : 32'd2);
        check("ramaddr", bus.ramaddr, mon_e.addr);
        check("strobes", {30'd0, bus.ramREN, bus.ramWEN},
              mon_e.is_wr ? 32'd1 : 32'd2);
        if (mon_e.is_wr)     check("ramstore", bus.ramstore, mon_e.data);
        else if (mon_e.is_i) check("iload", bus.iload, mon_e.data);
        else                 check("dload", bus.dload, mon_e.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requesters: hold the request until the hit, drop it after the next edge
  // ---------------------------------------------------------------------------
  task automatic i_req(input logic [31:0] a, output int lat);
    bus.iaddr = a;
    bus.iREN  = 1'b1;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (bus.iwait !== 1'b0 && lat < BUDGET);
    if (bus.iwait !== 1'b0) check("i_req_bound", {31'd0, bus.iwait}, 32'd0);
    @(posedge CLK);
    #1;
    bus.iREN = 1'b0;
  endtask

  task automatic d_req(input logic [31:0] a, input bit wr,
                       input logic [31:0] d, output int lat);
    bus.daddr  = a;
    bus.dstore = d;
    bus.dREN   = !wr;
    bus.dWEN   = wr;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (bus.dwait !== 1'b0 && lat < BUDGET);
    if (bus.dwait !== 1'b0) check("d_req_bound", {31'd0, bus.dwait}, 32'd0);
    @(posedge CLK);
    #1;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int lat_i;
  int lat_d;
  int n_busy;

  initial begin
    RST        = 1'b0;
    bus.iREN   = 1'b0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.iaddr  = 32'h0;
    bus.daddr  = 32'h0;
    bus.dstore = 32'h0;
    #2;
    RST = 1'b1;
    #2;

    // Reset values
    check("rst_iwait",    {31'd0, bus.iwait},  32'd1);
    check("rst_dwait",    {31'd0, bus.dwait},  32'd1);
    check("rst_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    check("rst_ramWEN",   {31'd0, bus.ramWEN}, 32'd0);
    check("rst_ramaddr",  bus.ramaddr,         32'h0);
    check("rst_ramstore", bus.ramstore,        32'h0);
    check("rst_err",      {31'd0, bus.err},    32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single fetch, minimum latency
    @(posedge CLK);
    #1;
    expect_txn(1'b1, 1'b0, 32'h100, 32'h8C22_0004);
    i_req(32'h100, lat_i);
    check("fetch_latency", 32'(lat_i), 32'd3);

    // Fetch and write together: the write goes first
    @(posedge CLK);
    #1;
    expect_txn(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF);
    expect_txn(1'b1, 1'b0, 32'h104, 32'hA5A5_0104);
    fork
      i_req(32'h104, lat_i);
      d_req(32'h200, 1'b1, 32'hDEAD_BEEF, lat_d);
    join

    // Fetch held across six back-to-back data reads: D,D,D,D,I,D,D
    @(posedge CLK);
    #1;
    expect_txn(1'b0, 1'b0, 32'h300, 32'hA5A5_0300);
    expect_txn(1'b0, 1'b0, 32'h304, 32'hA5A5_0304);
    expect_txn(1'b0, 1'b0, 32'h308, 32'hA5A5_0308);
    expect_txn(1'b0, 1'b0, 32'h30C, 32'hA5A5_030C);
    expect_txn(1'b1, 1'b0, 32'h140, 32'hA5A5_0140);
    expect_txn(1'b0, 1'b0, 32'h310, 32'hA5A5_0310);
    expect_txn(1'b0, 1'b0, 32'h314, 32'hA5A5_0314);
    fork
      i_req(32'h140, lat_i);
      begin
        for (int k = 0; k < 6; k++) d_req(32'h300 + 32'(4 * k), 1'b0, 32'h0, lat_d);
      end
    join

    // RAM stuck BUSY: abort after eight grant cycles, err set
    @(posedge CLK);
    #1;
    check("err_before_timeout", {31'd0, bus.err}, 32'd0);
    ram_mode = 1;
    bus.daddr = 32'h400;
    bus.dREN  = 1'b1;
    n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (bus.ramREN === 1'b1) n_busy++;
      else if (n_busy > 0) break;
    end
    bus.dREN = 1'b0;
    ram_mode = 0;
    check("timeout_cycles",    32'(n_busy),      32'd8);
    check("err_after_timeout", {31'd0, bus.err}, 32'd1);

    // Next request is served normally; err remains sticky
    @(posedge CLK);
    #1;
    expect_txn(1'b0, 1'b0, 32'h404, 32'hA5A5_0404);
    d_req(32'h404, 1'b0, 32'h0, lat_d);
    check("err_sticky", {31'd0, bus.err}, 32'd1);

    // Data read withdrawn while RAM is BUSY
    do_reset();
    check("err_cleared", {31'd0, bus.err}, 32'd0);
    @(posedge CLK);
    #1;
    ram_mode = 1;
    bus.daddr = 32'h500;
    bus.dREN  = 1'b1;
    repeat (2) @(negedge CLK);
    check("busy_grant_ren", {31'd0, bus.ramREN}, 32'd1);
    bus.dREN = 1'b0;
    @(negedge CLK);
    check("withdraw_ren", {31'd0, bus.ramREN}, 32'd0);
    check("withdraw_err", {31'd0, bus.err},    32'd0);
    ram_mode = 0;

    // RAM ERROR during a fetch
    @(posedge CLK);
    #1;
    ram_mode = 2;
    bus.iaddr = 32'h600;
    bus.iREN  = 1'b1;
    repeat (2) @(negedge CLK);
    check("error_grant_ren", {31'd0, bus.ramREN}, 32'd1);
    check("error_iwait",     {31'd0, bus.iwait},  32'd1);
    @(negedge CLK);
    check("error_err",       {31'd0, bus.err},    32'd1);
    check("error_ren_drop",  {31'd0, bus.ramREN}, 32'd0);
    bus.iREN = 1'b0;
    ram_mode = 0;

    // Reset in the ACCESS cycle of a fetch
    do_reset();
    @(posedge CLK);
    #1;
    bus.iaddr = 32'h700;
    bus.iREN  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("pre_reset_iwait", {31'd0, bus.iwait}, 32'd0);
    RST = 1'b1;
    #1;
    check("mid_rst_iwait",   {31'd0, bus.iwait},  32'd1);
    check("mid_rst_ramREN",  {31'd0, bus.ramREN}, 32'd0);
    check("mid_rst_ramaddr", bus.ramaddr,         32'h0);
    bus.iREN = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Idle after reset: a fresh read completes with minimum latency
    @(posedge CLK);
    #1;
    expect_txn(1'b0, 1'b0, 32'h704, 32'hA5A5_0704);
    d_req(32'h704, 1'b0, 32'h0, lat_d);
    check("post_rst_latency", 32'(lat_d), 32'd3);

    repeat (4) @(posedge CLK);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
